// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// bundle of per-stage load/clear strobes, plus constructors for the
// strobe patterns the sequencer drives.
package ctrl_types;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MULW = 2'd1,
        FRZ  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_load;
        logic ifid_load;
        logic idex_load;
        logic exmem_load;
        logic memwb_load;
        logic ifid_rst;
        logic idex_rst;
        logic exmem_rst;
        logic memwb_rst;
    } stage_ctrl_t;

    // Everything frozen: no stage loads, no stage clears.
    function automatic stage_ctrl_t ctrl_clear();
        stage_ctrl_t c;
        c = '0;
        return c;
    endfunction

    // Normal advance: every stage loads.
    function automatic stage_ctrl_t ctrl_run();
        stage_ctrl_t c;
        c = '0;
        c.pc_load    = 1'b1;
        c.ifid_load  = 1'b1;
        c.idex_load  = 1'b1;
        c.exmem_load = 1'b1;
        c.memwb_load = 1'b1;
        return c;
    endfunction

    // Held in reset: all stages cleared, none loading.
    function automatic stage_ctrl_t ctrl_reset();
        stage_ctrl_t c;
        c = '0;
        c.ifid_rst  = 1'b1;
        c.idex_rst  = 1'b1;
        c.exmem_rst = 1'b1;
        c.memwb_rst = 1'b1;
        return c;
    endfunction

    // Mispredict: redirect fetch and squash the two wrong-path stages.
    // The clear wins over the load inside the IF/ID and ID/EX registers.
    function automatic stage_ctrl_t ctrl_flush();
        stage_ctrl_t c;
        c = ctrl_run();
        c.ifid_rst = 1'b1;
        c.idex_rst = 1'b1;
        return c;
    endfunction

    // Multi-cycle op in EX: hold the front end, drain EX/MEM with a bubble.
    function automatic stage_ctrl_t ctrl_mul_wait();
        stage_ctrl_t c;
        c = '0;
        c.exmem_rst  = 1'b1;
        c.memwb_load = 1'b1;
        return c;
    endfunction

    // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
    function automatic stage_ctrl_t ctrl_load_use();
        stage_ctrl_t c;
        c = '0;
        c.idex_rst   = 1'b1;
        c.exmem_load = 1'b1;
        c.memwb_load = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard detection: the ID/EX load writes a register that the
// IF/ID instruction reads. Register 0 never creates a dependency.
import ctrl_types::*;

module hazard_unit #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 idex_mem_read,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic [REG_IDX_W-1:0] ifid_rs1,
    input  logic [REG_IDX_W-1:0] ifid_rs2,
    input  logic                 ifid_use_rs1,
    input  logic                 ifid_use_rs2,
    output logic                 lu
);

    // Pure combinational compare against both source operands.
    always_comb begin
        lu = idex_mem_read && (idex_rd != '0) &&
             ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
              (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five pipeline registers. Produces every stage
// load/clear strobe from cache stalls, load-use hazards, mispredicts and the
// multi-cycle multiply/divide unit. A freeze suspends RUN or MULW and
// resumes it afterwards. Optional macro PIPE_PERF_CNT_EN adds saturating
// freeze/bubble/flush performance counters.
import ctrl_types::*;

module pipeline_ctrl #(
    parameter int REG_IDX_W = 5
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_stall,
    input  logic                 mem_stall,
    input  logic                 idex_mem_read,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic [REG_IDX_W-1:0] ifid_rs1,
    input  logic [REG_IDX_W-1:0] ifid_rs2,
    input  logic                 ifid_use_rs1,
    input  logic                 ifid_use_rs2,
    input  logic                 ex_mispredict,
    input  logic                 ex_mul_start,
    input  logic                 ex_mul_done,
    output logic                 pc_load,
    output logic                 ifid_load,
    output logic                 idex_load,
    output logic                 exmem_load,
    output logic                 memwb_load,
    output logic                 ifid_rst,
    output logic                 idex_rst,
    output logic                 exmem_rst,
    output logic                 memwb_rst,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]     perf_freeze_cnt,
    output logic [CNT_W-1:0]     perf_bubble_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt,
`endif
    output logic [1:0]           state_o
);

    pipe_state_t state, state_next;
    pipe_state_t saved_state, saved_next;
    pipe_state_t eff_state;
    stage_ctrl_t ctrl;
    logic        freeze;
    logic        lu;

    assign freeze = if_stall | mem_stall;

    hazard_unit #(.REG_IDX_W(REG_IDX_W)) u_hazard (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_use_rs1  (ifid_use_rs1),
        .ifid_use_rs2  (ifid_use_rs2),
        .lu            (lu)
    );

    // State and return-state registers; reset discards any suspended state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            saved_state <= RUN;
        end else begin
            state       <= state_next;
            saved_state <= saved_next;
        end
    end

    // Next state and stage strobes. Leaving FRZ, the cycle behaves as the
    // saved state, so the resumed work is not delayed by an extra cycle.
    always_comb begin
        ctrl       = ctrl_clear();
        state_next = state;
        saved_next = saved_state;
        eff_state  = (state == FRZ) ? saved_state : state;
        if (rst) begin
            ctrl       = ctrl_reset();
            state_next = RUN;
            saved_next = RUN;
        end else if (freeze) begin
            if (state != FRZ) begin
                saved_next = state;
                state_next = FRZ;
            end
        end else begin
            state_next = eff_state;
            if (eff_state == MULW) begin
                if (ex_mul_done) begin
                    ctrl       = ex_mispredict ? ctrl_flush() : ctrl_run();
                    state_next = RUN;
                end else begin
                    ctrl = ctrl_mul_wait();
                end
            end else begin
                if (ex_mispredict) begin
                    ctrl       = ctrl_flush();
                    state_next = RUN;
                end else if (ex_mul_start) begin
                    if (ex_mul_done) begin
                        ctrl       = ctrl_run();
                        state_next = RUN;
                    end else begin
                        ctrl       = ctrl_mul_wait();
                        state_next = MULW;
                    end
                end else if (lu) begin
                    ctrl       = ctrl_load_use();
                    state_next = RUN;
                end else begin
                    ctrl       = ctrl_run();
                    state_next = RUN;
                end
            end
        end
    end

    assign pc_load    = ctrl.pc_load;
    assign ifid_load  = ctrl.ifid_load;
    assign idex_load  = ctrl.idex_load;
    assign exmem_load = ctrl.exmem_load;
    assign memwb_load = ctrl.memwb_load;
    assign ifid_rst   = ctrl.ifid_rst;
    assign idex_rst   = ctrl.idex_rst;
    assign exmem_rst  = ctrl.exmem_rst;
    assign memwb_rst  = ctrl.memwb_rst;
    assign state_o    = state;

`ifdef PIPE_PERF_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic ev_freeze, ev_bubble, ev_flush;

    // Outside reset, an IF/ID clear only comes from a mispredict, an EX/MEM
    // clear only from a multi-cycle wait, and a lone ID/EX clear from load-use.
    assign ev_freeze = !rst && freeze;
    assign ev_bubble = !rst && (ctrl.exmem_rst || (ctrl.idex_rst && !ctrl.ifid_rst));
    assign ev_flush  = !rst && ctrl.ifid_rst;

    // Event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_freeze_cnt <= '0;
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (ev_freeze) perf_freeze_cnt <= sat_inc(perf_freeze_cnt);
            if (ev_bubble) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
            if (ev_flush)  perf_flush_cnt  <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, compared each cycle against a behavioural model that
// only tracks "frozen" and "multi-cycle op pending".
module tb_pipeline_ctrl;

    localparam int RW = 5;

    // {pc, ifid, idex, exmem, memwb loads, ifid, idex, exmem, memwb clears}
    localparam logic [8:0] E_GO    = 9'b11111_0000;
    localparam logic [8:0] E_FLUSH = 9'b11111_1100;
    localparam logic [8:0] E_MULW  = 9'b00001_0010;
    localparam logic [8:0] E_LU    = 9'b00011_0100;
    localparam logic [8:0] E_RST   = 9'b00000_1111;
    localparam logic [8:0] E_FRZ   = 9'b00000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, if_stall, mem_stall, idex_mem_read;
    logic [RW-1:0] idex_rd, ifid_rs1, ifid_rs2;
    logic ifid_use_rs1, ifid_use_rs2, ex_mispredict, ex_mul_start, ex_mul_done;
    logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic ifid_rst, idex_rst, exmem_rst, memwb_rst;
    logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_freeze_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

    pipeline_ctrl #(.REG_IDX_W(RW)) dut (
        .clk(clk), .rst(rst), .if_stall(if_stall), .mem_stall(mem_stall),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .ex_mispredict(ex_mispredict), .ex_mul_start(ex_mul_start),
        .ex_mul_done(ex_mul_done),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_rst(ifid_rst), .idex_rst(idex_rst), .exmem_rst(exmem_rst),
        .memwb_rst(memwb_rst),
`ifdef PIPE_PERF_CNT_EN
        .perf_freeze_cnt(perf_freeze_cnt), .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .state_o(state_o)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    bit m_mul = 1'b0;   // a multi-cycle op is waiting in EX
    bit m_frz = 1'b0;   // the pipeline is frozen this cycle

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // The multi-cycle unit must never report done while the pipe is frozen.
    always @(negedge clk) begin
        if (!rst && (if_stall || mem_stall))
            assert (!ex_mul_done) else $error("ex_mul_done during freeze");
    end

    task automatic idle();
        if_stall = 0; mem_stall = 0; idex_mem_read = 0; idex_rd = '0;
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
        ex_mispredict = 0; ex_mul_start = 0; ex_mul_done = 0; rst = 0;
    endtask

    // Evaluate one cycle with the inputs currently driven: compare outputs
    // at the falling edge, then advance the model across the rising edge.
    task automatic step(input string tag);
        logic [8:0] exp;
        logic [1:0] exp_st;
        bit fz, lu, nm, nf;
        fz = if_stall || mem_stall;
        lu = idex_mem_read && (idex_rd != 0) &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        exp_st = m_frz ? 2'd2 : (m_mul ? 2'd1 : 2'd0);
        nm = m_mul;
        nf = 1'b0;
        if (rst) begin
            exp = E_RST; nm = 0;
        end else if (fz) begin
            exp = E_FRZ; nf = 1;
        end else if (m_mul && !ex_mul_done) begin
            exp = E_MULW;
        end else if (ex_mispredict) begin
            exp = E_FLUSH; nm = 0;
        end else if (m_mul) begin
            exp = E_GO; nm = 0;
        end else if (ex_mul_start) begin
            exp = ex_mul_done ? E_GO : E_MULW;
            nm  = !ex_mul_done;
        end else if (lu) begin
            exp = E_LU;
        end else begin
            exp = E_GO;
        end
        @(negedge clk);
        check({tag, "/strobes"},
              {23'd0, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_rst, idex_rst, exmem_rst, memwb_rst}, {23'd0, exp});
        check({tag, "/state"}, {30'd0, state_o}, {30'd0, exp_st});
        @(posedge clk);
        m_mul = nm;
        m_frz = nf;
        #1;
    endtask

    initial begin
        bit fz;
        idle();
        rst = 1;
        @(posedge clk); #1;
        step("reset0");
        step("reset1");

        idle();
        step("run_idle");
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
        step("lu_rs1");
        idle();
        step("lu_release");
        idex_mem_read = 1; idex_rd = 7; ifid_rs2 = 7; ifid_use_rs2 = 1;
        step("lu_rs2");
        idle();
        idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
        step("lu_rd0");
        idex_rd = 5; ifid_rs1 = 5; ex_mispredict = 1;
        step("mp_over_lu");
        idle();
        step("mp_after");

        ex_mul_start = 1;
        step("mul_c1");
        step("mul_c2");
        step("mul_c3");
        ex_mul_done = 1;
        step("mul_done");
        idle();
        step("mul_after");

        ex_mul_start = 1;
        step("mulf_c1");
        step("mulf_c2");
        mem_stall = 1;
        step("mulf_frz1");
        step("mulf_frz2");
        step("mulf_frz3");
        mem_stall = 0;
        step("mulf_resume");
        ex_mul_done = 1; ex_mispredict = 1;
        step("mulf_done_mp");
        idle();

        if_stall = 1;
        step("frz_enter");
        rst = 1;
        step("frz_rst");
        idle();
        step("post_rst");
`ifdef PIPE_PERF_CNT_EN
        check("perf_freeze_zero", perf_freeze_cnt, 32'd0);
        check("perf_bubble_zero", perf_bubble_cnt, 32'd0);
        check("perf_flush_zero", perf_flush_cnt, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            idle();
            rst = ($urandom_range(0, 99) < 1);
            fz = ($urandom_range(0, 99) < 12);
            if (fz) begin
                if ($urandom_range(0, 1) == 0) if_stall = 1; else mem_stall = 1;
            end
            idex_mem_read = ($urandom_range(0, 99) < 40);
            idex_rd  = RW'($urandom_range(0, 3));
            ifid_rs1 = RW'($urandom_range(0, 3));
            ifid_rs2 = RW'($urandom_range(0, 3));
            ifid_use_rs1 = $urandom_range(0, 1);
            ifid_use_rs2 = $urandom_range(0, 1);
            ex_mispredict = ($urandom_range(0, 99) < 10);
            ex_mul_start = m_mul ? 1'b1 : ($urandom_range(0, 99) < 20);
            ex_mul_done = ex_mul_start && !fz && ($urandom_range(0, 99) < 35);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
